// File: rtl/alu4_shift.sv
// 4-bit ALU (add/sub/mul/xor) with a left-shift, right-shift or nibble-swap modifier.
// The 8-bit result is registered, so each value appears one clock after its inputs.
module alu4_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [1:0] operationSelect,
  input  logic       shiftButton1,
  input  logic       shiftButton2,
  output logic [7:0] result
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [7:0] raw_next;
  logic [7:0] shl_next;
  logic [7:0] shr_next;
  logic [7:0] swap_next;
  logic [7:0] result_next;
  logic [7:0] result_reg;

  assign a_ext = {4'b0000, num1};
  assign b_ext = {4'b0000, num2};

  // Zero-extending before the arithmetic makes SUB wrap in 8-bit two's complement.
  always_comb begin
    raw_next = 8'h00;
    unique case (operationSelect)
      OP_ADD:  raw_next = a_ext + b_ext;
      OP_SUB:  raw_next = a_ext - b_ext;
      OP_MUL:  raw_next = a_ext * b_ext;
      OP_XOR:  raw_next = {4'b0000, num1 ^ num2};
      default: raw_next = 8'h00;
    endcase
  end

  // Right shift is logical even for negative SUB results.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      if (gi == 0) begin : g_shl_lsb
        assign shl_next[gi] = 1'b0;
      end else begin : g_shl_bit
        assign shl_next[gi] = raw_next[gi-1];
      end
      if (gi == 7) begin : g_shr_msb
        assign shr_next[gi] = 1'b0;
      end else begin : g_shr_bit
        assign shr_next[gi] = raw_next[gi+1];
      end
      assign swap_next[gi] = raw_next[(gi + 4) % 8];
    end
  endgenerate

  always_comb begin
    result_next = raw_next;
    unique case ({shiftButton1, shiftButton2})
      2'b00:   result_next = raw_next;
      2'b10:   result_next = shl_next;
      2'b01:   result_next = shr_next;
      2'b11:   result_next = swap_next;
      default: result_next = raw_next;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg <= 8'h00;
    end else begin
      result_reg <= result_next;
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_alu4_shift.sv
// Directed, table-driven bench for alu4_shift with hand-computed expected results,
// plus hand-written sequences for async reset and input-hold timing.
module tb_alu4_shift;

  logic       clk;
  logic       rst;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [1:0] operationSelect;
  logic       shiftButton1;
  logic       shiftButton2;
  logic [7:0] result;

  int tests_run;
  int tests_failed;

  alu4_shift dut (
    .clk             (clk),
    .rst             (rst),
    .num1            (num1),
    .num2            (num2),
    .operationSelect (operationSelect),
    .shiftButton1    (shiftButton1),
    .shiftButton2    (shiftButton2),
    .result          (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       s1;
    logic       s2;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: result %h", name, act);
    end
  endtask

  task automatic drive(input vec_t v);
    num1            = v.a;
    num2            = v.b;
    operationSelect = v.op;
    shiftButton1    = v.s1;
    shiftButton2    = v.s2;
  endtask

  // Drive on the falling edge, check 1 time unit after the next rising edge.
  task automatic apply_and_check(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(v.name, result, v.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{"add_a5",       4'hA, 4'h5, 2'b00, 1'b0, 1'b0, 8'h0F};
    vecs[1]  = '{"sub_a5",       4'hA, 4'h5, 2'b01, 1'b0, 1'b0, 8'h05};
    vecs[2]  = '{"mul_a5",       4'hA, 4'h5, 2'b10, 1'b0, 1'b0, 8'h32};
    vecs[3]  = '{"xor_a5",       4'hA, 4'h5, 2'b11, 1'b0, 1'b0, 8'h0F};
    vecs[4]  = '{"mul_a5_shl",   4'hA, 4'h5, 2'b10, 1'b1, 1'b0, 8'h64};
    vecs[5]  = '{"sub_a5_shr",   4'hA, 4'h5, 2'b01, 1'b0, 1'b1, 8'h02};
    vecs[6]  = '{"xor_a5_swap",  4'hA, 4'h5, 2'b11, 1'b1, 1'b1, 8'hF0};
    vecs[7]  = '{"mul_ff",       4'hF, 4'hF, 2'b10, 1'b0, 1'b0, 8'hE1};
    vecs[8]  = '{"mul_ff_shl",   4'hF, 4'hF, 2'b10, 1'b1, 1'b0, 8'hC2};
    vecs[9]  = '{"add_ff",       4'hF, 4'hF, 2'b00, 1'b0, 1'b0, 8'h1E};
    vecs[10] = '{"sub_01",       4'h0, 4'h1, 2'b01, 1'b0, 1'b0, 8'hFF};
    vecs[11] = '{"sub_01_shr",   4'h0, 4'h1, 2'b01, 1'b0, 1'b1, 8'h7F};
    vecs[12] = '{"sub_5a",       4'h5, 4'hA, 2'b01, 1'b0, 1'b0, 8'hFB};
    vecs[13] = '{"sub_5a_shr",   4'h5, 4'hA, 2'b01, 1'b0, 1'b1, 8'h7D};
    vecs[14] = '{"sub_5a_shl",   4'h5, 4'hA, 2'b01, 1'b1, 1'b0, 8'hF6};
    vecs[15] = '{"add_ff_shr",   4'hF, 4'hF, 2'b00, 1'b0, 1'b1, 8'h0F};
    vecs[16] = '{"mul_ff_swap",  4'hF, 4'hF, 2'b10, 1'b1, 1'b1, 8'h1E};
    vecs[17] = '{"xor_3c",       4'h3, 4'hC, 2'b11, 1'b0, 1'b0, 8'h0F};
    vecs[18] = '{"mul_07_swap",  4'h7, 4'h3, 2'b10, 1'b1, 1'b1, 8'h51};
    vecs[19] = '{"add_00",       4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 8'h00};

    // Async reset with arbitrary inputs; checked before any clock edge.
    rst = 1'b0;
    drive(vecs[7]);
    #1;
    rst = 1'b1;
    #1;
    check("reset_async", result, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold", result, 8'h00);

    // First edge after release reflects the inputs present at that edge.
    @(negedge clk);
    rst = 1'b0;
    drive(vecs[2]);
    @(posedge clk);
    #1;
    check("first_after_release", result, 8'h32);

    for (int i = 0; i < 20; i++) begin
      apply_and_check(vecs[i]);
    end

    // Inputs changed between edges must not reach result until the next rising edge.
    apply_and_check(vecs[8]);
    @(negedge clk);
    drive(vecs[12]);
    #2;
    check("hold_between_edges", result, 8'hC2);
    @(posedge clk);
    #1;
    check("update_at_edge", result, 8'hFB);

    // Reset mid-stream drops result immediately, then operation resumes.
    #2;
    rst = 1'b1;
    #1;
    check("reset_midstream", result, 8'h00);
    @(posedge clk);
    #1;
    check("reset_midstream_hold", result, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(vecs[4]);
    @(posedge clk);
    #1;
    check("resume_after_reset", result, 8'h64);
    apply_and_check(vecs[11]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
